// File: rtl/kernel_altmemddr_0_ex_lfsr8_chk_pkg.sv
// Shared definitions for the 8-bit LFSR read-side checker and its write-side twin.
// The lfsr_next taps must stay bit-identical to the generator's.
package kernel_altmemddr_0_ex_lfsr8_chk_pkg;

    localparam int LFSR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

    // An all-zero seed would lock the LFSR, so it is swapped for all-ones.
    function automatic logic [LFSR_W-1:0] lane_seed(input logic [LFSR_W-1:0] base, input int lane);
        logic [LFSR_W-1:0] s;
        s = base + LFSR_W'(lane);
        return (s == '0) ? '1 : s;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[6], s[5], s[4], s[3] ^ s[7], s[2] ^ s[7], s[1] ^ s[7], s[0], s[7]};
    endfunction

endpackage

// File: rtl/kernel_altmemddr_0_ex_lfsr8_chk_exp.sv
// Per-lane expected-value LFSR: loads its seed on reset or start, steps on each accepted beat.
module kernel_altmemddr_0_ex_lfsr8_exp
    import kernel_altmemddr_0_ex_lfsr8_chk_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [LFSR_W-1:0] exp_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (reset_i || load_i) begin
            lfsr_d = seed_i;
        end else if (adv_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        lfsr_q <= lfsr_d;
    end

    assign exp_o = lfsr_q;

endmodule

// File: rtl/kernel_altmemddr_0_ex_lfsr8_chk.sv
// Read-side LFSR pattern checker: compares read beats against regenerated per-lane
// sequences and reports sticky lane errors, a failing-beat count and a run verdict.
module kernel_altmemddr_0_ex_lfsr8_chk
    import kernel_altmemddr_0_ex_lfsr8_chk_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int SEED      = 32,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CNT_W-1:0]       burst_len,
    input  logic                   rdata_valid,
    input  logic [8*NUM_LANES-1:0] rdata,
    output logic                   chk_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_LANES-1:0]   lane_err,
    output logic [CNT_W-1:0]       err_count,
    output logic [CNT_W-1:0]       first_err_idx,
    output logic                   unexp_beat
);

    localparam logic [LFSR_W-1:0] SEED_B = LFSR_W'(SEED);

    chk_state_e                          state_q, state_d;
    logic       [CNT_W-1:0]              idx_q, idx_d;
    logic       [CNT_W-1:0]              len_q, len_d;
    logic       [NUM_LANES-1:0]          lerr_q, lerr_d;
    logic       [CNT_W-1:0]              cnt_q, cnt_d;
    logic       [CNT_W-1:0]              first_q, first_d;
    logic                                unexp_q, unexp_d;
    logic                                adv_w;
    logic       [NUM_LANES-1:0]          mm_w;
    logic       [NUM_LANES-1:0][LFSR_W-1:0] exp_w;

    // start outranks a coincident beat, so that beat never moves the LFSRs.
    assign adv_w = (state_q == ST_RUN) && rdata_valid && !start;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [LFSR_W-1:0] LANE_SEED = lane_seed(SEED_B, i);
        kernel_altmemddr_0_ex_lfsr8_exp u_exp (
            .clk_i   (clk),
            .reset_i (reset),
            .load_i  (start),
            .adv_i   (adv_w),
            .seed_i  (LANE_SEED),
            .exp_o   (exp_w[i])
        );
        assign mm_w[i] = (rdata[8*i +: 8] != exp_w[i]);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        lerr_d  = lerr_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        unexp_d = unexp_q;
        if (start) begin
            state_d = (burst_len == '0) ? ST_DONE : ST_RUN;
            idx_d   = '0;
            len_d   = burst_len;
            lerr_d  = '0;
            cnt_d   = '0;
            first_d = '0;
            unexp_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (rdata_valid) begin
                lerr_d = lerr_q | mm_w;
                if (|mm_w) begin
                    if (cnt_q == '0) first_d = idx_q;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end
                idx_d = idx_q + CNT_W'(1);
                if (idx_q == len_q - CNT_W'(1)) state_d = ST_DONE;
            end
        end else if (rdata_valid) begin
            unexp_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            len_q   <= '0;
            lerr_q  <= '0;
            cnt_q   <= '0;
            first_q <= '0;
            unexp_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            len_q   <= len_d;
            lerr_q  <= lerr_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            unexp_q <= unexp_d;
        end
    end

    assign chk_ready     = (state_q == ST_RUN);
    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_DONE);
    assign pass          = (state_q == ST_DONE) && (cnt_q == '0);
    assign lane_err      = lerr_q;
    assign err_count     = cnt_q;
    assign first_err_idx = first_q;
    assign unexp_beat    = unexp_q;

endmodule

// File: doc/kernel_altmemddr_0_ex_lfsr8_chk.md
Name: kernel_altmemddr_0_ex_lfsr8_chk

Overview:
Read-side pattern checker for the memory example driver. The write side produces per-byte-lane 8-bit LFSR data. This block regenerates the identical expected sequence for every lane, compares it against read-back beats, and reports per-lane sticky errors, an error count and a pass/fail verdict for a run of N beats. It sits between the controller's read-data path and the driver's test-status logic.

Parameters:
NUM_LANES, 4, byte lanes per beat; data width is 8*NUM_LANES.
SEED, 32, base seed. Lane i seed is (SEED[7:0]+i) mod 256; a result of 8'h00 is replaced by 8'hFF.
CNT_W, 16, width of the beat-length input, beat index and error counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: reload all lane seeds, clear statistics, begin a run
burst_len  in  CNT_W  number of beats in the run; sampled when start=1
rdata_valid  in  1  read beat present
rdata  in  8*NUM_LANES  read beat; lane i is bits [8i+7:8i]
chk_ready  out  1  high only in RUN
busy  out  1  high in RUN
done  out  1  high in DONE
pass  out  1  high in DONE when err_count==0
lane_err  out  NUM_LANES  sticky per-lane mismatch flags
err_count  out  CNT_W  number of beats with at least one mismatching lane; saturates at all-ones
first_err_idx  out  CNT_W  beat index (0-based) of the first failing beat; valid when err_count!=0
unexp_beat  out  1  sticky; set by rdata_valid while not in RUN

Behaviour:
- Reset (sync, high): FSM=IDLE, every lane LFSR=its seed. All outputs 0: chk_ready, busy, done, pass, lane_err, err_count, first_err_idx, unexp_beat.
- LFSR next-state per lane s→n:
  - n0=s7, n1=s0, n2=s1^s7, n3=s2^s7, n4=s3^s7, n5=s4, n6=s5, n7=s6.
  - This must match the write-side generator bit for bit.
- FSM: IDLE, RUN, DONE.
  - Any state with start=1 → RUN. Seeds are reloaded, lane_err/err_count/first_err_idx/unexp_beat cleared, beat index=0, burst_len latched. Start wins over any simultaneous beat, and that beat is neither checked nor flagged.
  - If the latched burst_len==0, the next cycle is DONE with pass=1 instead of RUN.
  - RUN, rdata_valid=1: compare rdata against the current expected value of every lane, then advance every LFSR and the beat index. rdata_valid=0 holds the LFSRs (pause).
  - RUN, on the accepted beat with index burst_len-1 → DONE.
  - DONE holds until start or reset.
- Latency:
  - Compare results are registered. lane_err, err_count and first_err_idx reflect beat k in the cycle after beat k is accepted.
  - done and pass rise in the cycle after the final beat is accepted, and include that beat's result.
- Mismatch on beat k:
  - lane_err[i] |= (rdata lane i != exp lane i).
  - err_count increments by 1 per failing beat, not per lane, and saturates.
  - first_err_idx=k only if err_count was 0.
- rdata_valid in IDLE or DONE: beat ignored, unexp_beat set, LFSRs untouched.
- Reset mid-run: returns to IDLE immediately with everything cleared; the run is abandoned.
- start during RUN: restarts the run from the seeds, discarding partial statistics.

Decomposition:
- Shared package: LFSR width constant (8), lane-seed derivation function, LFSR next-state function (shared with the generator), FSM state enum.
- Sub-module kernel_altmemddr_0_ex_lfsr8_exp: one per-lane expected-value LFSR with load/advance, instantiated NUM_LANES times.

Test Plan:
- Clean run: defaults, burst_len=5, lane 0 driven 0x20,0x40,0x80,0x1D,0x3A and lane 1 driven 0x21,0x42,0x84,0x15,0x2A, with lanes 2 and 3 driven correctly → done=1, pass=1, err_count=0, lane_err=0, one cycle after the 5th beat.
- Pause: same data with rdata_valid gaps of 1–3 cycles between beats → identical clean result; LFSRs hold during gaps.
- Single error: beat 2 lane 1 driven 0x85 instead of 0x84 → lane_err=4'b0010, err_count=1, first_err_idx=2, pass=0 at done.
- Multi-lane errors: beats 1 and 3 corrupt lanes 0 and 3 → lane_err=4'b1001, err_count=2, first_err_idx=1.
- Edges: burst_len=0 → done/pass the cycle after start; rdata_valid in IDLE → unexp_beat=1; start coincident with a valid beat → that beat is ignored and the first expected value is still 0x20.
- Reset and restart: reset asserted after 3 beats → all outputs 0, FSM IDLE. A fresh start during RUN clears err_count and the expectation restarts at the seed.
